// File: rtl/pipe_pkg.sv
// Shared types for the IF->ID pipeline register.
// Default widths, state encoding and the inter-stage bundle.
package pipe_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        EMPTY,
        BUSY,
        FULL
    } pipe_state_t;

    typedef struct packed {
        logic [XLEN_DEF-1:0] instr;
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] pc4;
    } if_id_t;

endpackage

// File: rtl/pipe_slot.sv
// One valid+payload register with load and clear.
// Clear keeps payload bits outside CLR_MASK, so PCs survive a kill.
module pipe_slot #(
    parameter int             W        = 96,
    parameter logic [W-1:0]   RST_VAL  = '0,
    parameter logic [W-1:0]   CLR_MASK = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            q     <= RST_VAL;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= (q & ~CLR_MASK) | (RST_VAL & CLR_MASK);
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// IF->ID stage register with valid/ready, flush, bubble count
// and an optional skid slot that keeps in_ready registered.
module if_id_stage
    import pipe_pkg::*;
#(
    parameter int               XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0]  NOP_INSTR = XLEN'(NOP_INSTR_DEF),
    parameter int               SKID      = 1,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_pc4,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_pc4,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } slot_t;

    pipe_state_t state_q;
    pipe_state_t state_d;
    slot_t       in_d;
    slot_t       main_d;
    slot_t       main_q;
    slot_t       skid_q;
    logic        main_v;
    logic        skid_v;
    logic        main_ld;
    logic        main_clr;
    logic        skid_ld;
    logic        skid_clr;
    logic        rdy_q;
    logic        in_fire;
    logic        out_fire;

    assign in_d     = {in_instr, in_pc, in_pc4};
    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_v & out_ready;

    assign out_valid = main_v;
    assign out_instr = main_q.instr;
    assign out_pc    = main_q.pc;
    assign out_pc4   = main_q.pc4;

    always_comb begin
        state_d  = state_q;
        main_ld  = 1'b0;
        main_clr = 1'b0;
        skid_ld  = 1'b0;
        skid_clr = 1'b0;
        main_d   = skid_v ? skid_q : in_d;
        if (flush) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_ld = 1'b1;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_ld = 1'b1;
                    end else if (in_fire && SKID != 0) begin
                        skid_ld = 1'b1;
                        state_d = FULL;
                    end else if (out_fire) begin
                        main_clr = 1'b1;
                        state_d  = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_ld  = 1'b1;
                        skid_clr = 1'b1;
                        state_d  = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            rdy_q      <= 1'b1;
            bubble_cnt <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != FULL);
            if (!main_v && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    pipe_slot #(
        .W        (3*XLEN),
        .RST_VAL  ({NOP_INSTR, {(2*XLEN){1'b0}}}),
        .CLR_MASK ({{XLEN{1'b1}}, {(2*XLEN){1'b0}}})
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_ld),
        .clear (main_clr),
        .d     (main_d),
        .valid (main_v),
        .q     (main_q)
    );

    if (SKID != 0) begin : g_skid
        pipe_slot #(
            .W (3*XLEN)
        ) u_skid (
            .clk   (clk),
            .reset (reset),
            .load  (skid_ld),
            .clear (skid_clr),
            .d     (in_d),
            .valid (skid_v),
            .q     (skid_q)
        );
        // Registered ready: no path from out_ready.
        assign in_ready = rdy_q & ~reset;
    end else begin : g_noskid
        assign skid_v   = 1'b0;
        assign skid_q   = '0;
        assign in_ready = ~reset & (out_ready | ~main_v);
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: skid build plus a
// no-skid build with a narrow bubble counter.
module tb_if_id_stage;
    import pipe_pkg::*;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_pc4;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic [15:0] bubble_cnt;

    logic        in_valid0;
    logic        in_ready0;
    logic        flush0;
    logic        out_valid0;
    logic        out_ready0;
    logic [31:0] out_instr0;
    logic [31:0] out_pc0;
    logic [31:0] out_pc40;
    logic [3:0]  bubble_cnt0;

    int          n_chk = 0;
    int          n_err = 0;
    if_id_t      sb[$];
    if_id_t      exp_t;
    logic [15:0] bub_snap;

    always #5 clk = ~clk;

    if_id_stage u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .in_pc4     (in_pc4),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_pc4    (out_pc4),
        .bubble_cnt (bubble_cnt)
    );

    if_id_stage #(
        .SKID  (0),
        .CNT_W (4)
    ) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid0),
        .in_ready   (in_ready0),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .in_pc4     (in_pc4),
        .flush      (flush0),
        .out_valid  (out_valid0),
        .out_ready  (out_ready0),
        .out_instr  (out_instr0),
        .out_pc     (out_pc0),
        .out_pc4    (out_pc40),
        .bubble_cnt (bubble_cnt0)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] i, input logic [31:0] p);
        in_valid = 1'b1;
        in_instr = i;
        in_pc    = p;
        in_pc4   = p + 32'd4;
    endtask

    // Transfers are decided mid-cycle: inputs are stable until next edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                check("sb_pop", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t = sb.pop_front();
                    check("sb_instr", out_instr, exp_t.instr);
                    check("sb_pc", out_pc, exp_t.pc);
                    check("sb_pc4", out_pc4, exp_t.pc4);
                end
            end
            if (flush)
                sb.delete();
            else if (in_valid && in_ready)
                sb.push_back({in_instr, in_pc, in_pc4});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        in_valid   = 1'b0;
        in_instr   = '0;
        in_pc      = '0;
        in_pc4     = '0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        in_valid0  = 1'b0;
        flush0     = 1'b0;
        out_ready0 = 1'b1;

        #2;
        check("rst_valid", out_valid, 0);
        check("rst_instr", out_instr, NOP_INSTR_DEF);
        check("rst_pcs", {out_pc, out_pc4}, 0);
        check("rst_rdy", in_ready, 0);
        check("rst_rdy0", in_ready0, 0);
        check("rst_bub", bubble_cnt, 0);

        @(negedge clk);
        reset = 1'b0;
        #1 check("rel_rdy", in_ready, 1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("idle_bub", bubble_cnt, 10);
        check("idle_bub0", bubble_cnt0, 10);
        check("idle_valid", out_valid, 0);
        check("idle_instr", out_instr, NOP_INSTR_DEF);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("idle_bub20", bubble_cnt, 20);
        check("sat_bub0", bubble_cnt0, 15);

        // Streaming
        cyc();
        put(32'h2002_0005, 32'h0);
        cyc();
        check("st_a_valid", out_valid, 1);
        check("st_a_instr", out_instr, 32'h2002_0005);
        bub_snap = bubble_cnt;
        put(32'h2003_0007, 32'h4);
        cyc();
        check("st_b_valid", out_valid, 1);
        check("st_b_instr", out_instr, 32'h2003_0007);
        check("st_nobub", bubble_cnt, bub_snap);
        in_valid = 1'b0;
        cyc();
        check("st_idle", out_valid, 0);

        // Backpressure into the skid slot
        out_ready = 1'b0;
        put(32'h0000_0013, 32'h100);
        cyc();
        put(32'h0010_0093, 32'h104);
        check("bp_rdy_busy", in_ready, 1);
        cyc();
        put(32'h0020_0113, 32'h108);
        check("bp_rdy_full", in_ready, 0);
        check("bp_main", out_instr, 32'h0000_0013);
        cyc();
        check("bp_stall_instr", out_instr, 32'h0000_0013);
        check("bp_stall_pc", out_pc, 32'h100);
        check("bp_stall_rdy", in_ready, 0);
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 10) begin
            cyc();
            n++;
        end
        check("bp_c_accept", 64'(n < 10), 1);
        cyc();
        in_valid = 1'b0;
        repeat (2) cyc();
        check("bp_drain", sb.size(), 0);
        check("bp_idle", out_valid, 0);

        // Flush while FULL, with a delivery in the same cycle
        out_ready = 1'b0;
        put(32'h0030_0193, 32'h200);
        cyc();
        put(32'h0040_0213, 32'h204);
        cyc();
        flush     = 1'b1;
        out_ready = 1'b1;
        put(32'h0050_0293, 32'h208);
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_instr", out_instr, NOP_INSTR_DEF);
        check("fl_rdy", in_ready, 1);
        check("fl_pc_hold", out_pc, 32'h200);
        check("fl_sb", sb.size(), 0);
        cyc();
        check("fl_valid2", out_valid, 0);

        // Flush while BUSY with a real in_fire: the new entry is dropped
        out_ready = 1'b0;
        put(32'h0060_0313, 32'h300);
        cyc();
        check("fb_rdy", in_ready, 1);
        flush = 1'b1;
        put(32'h0070_0393, 32'h304);
        cyc();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("fb_valid", out_valid, 0);
        check("fb_pc_hold", out_pc, 32'h300);
        repeat (2) cyc();
        check("fb_drop", out_valid, 0);

        // Asynchronous reset while BUSY
        out_ready = 1'b0;
        put(32'h0080_0413, 32'h400);
        cyc();
        in_valid = 1'b0;
        check("mr_busy", out_valid, 1);
        #3;
        reset = 1'b1;
        sb.delete();
        #1;
        check("mr_valid", out_valid, 0);
        check("mr_instr", out_instr, NOP_INSTR_DEF);
        check("mr_pcs", {out_pc, out_pc4}, 0);
        check("mr_bub", bubble_cnt, 0);
        check("mr_rdy", in_ready, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mr_rel_rdy", in_ready, 1);
        check("mr_rel_valid", out_valid, 0);

        // No-skid build: combinational ready
        cyc();
        out_ready0 = 1'b0;
        in_valid0  = 1'b1;
        in_instr   = 32'h0090_0493;
        in_pc      = 32'h500;
        in_pc4     = 32'h504;
        check("s0_rdy_empty", in_ready0, 1);
        cyc();
        check("s0_valid", out_valid0, 1);
        check("s0_instr", out_instr0, 32'h0090_0493);
        check("s0_rdy_stall", in_ready0, 0);
        in_instr = 32'h00a0_0513;
        in_pc    = 32'h504;
        in_pc4   = 32'h508;
        cyc();
        check("s0_hold", out_instr0, 32'h0090_0493);
        out_ready0 = 1'b1;
        #1 check("s0_rdy_comb", in_ready0, 1);
        cyc();
        check("s0_next", out_instr0, 32'h00a0_0513);
        check("s0_next_valid", out_valid0, 1);
        in_valid0 = 1'b0;
        cyc();
        check("s0_empty", out_valid0, 0);
        check("s0_nop", out_instr0, NOP_INSTR_DEF);
        check("s0_pc_hold", out_pc0, 32'h504);

        check("sb_final", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
